// File: rtl/mem_if_pkg.sv
// mem_if_pkg
// Shared definitions for the MAR/MDR memory-interface unit.
//   - DEF_DATA_W / DEF_ADDR_W / DEF_TIMEOUT : default parameter values
//   - state_t, IDLE, ACCESS                 : transaction FSM encoding
package mem_if_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 9;
    localparam int DEF_TIMEOUT = 15;

    // A plain vector type with named constants keeps the encoding visible
    // to older tools and waveform viewers.
    typedef logic [0:0] state_t;

    localparam state_t IDLE   = 1'b0;
    localparam state_t ACCESS = 1'b1;

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer
// Counts the cycles a memory request has been outstanding and raises
// 'expired' on the cycle whose edge would be the TIMEOUT-th without ack.
// Ports:
//   clock   in  system clock, rising edge
//   clear   in  asynchronous active-low reset
//   start   in  restart the count from zero (transaction accepted)
//   count   in  advance the count by one (waiting, no ack this cycle)
//   expired out high while the count equals TIMEOUT-1; never high when TIMEOUT=0
module mem_wait_timer
    import mem_if_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clock,
    input  logic clear,
    input  logic start,
    input  logic count,
    output logic expired
);

    // A zero-width counter is illegal, so a disabled timer keeps one bit.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] MAX  = '1;

    logic [CNT_W-1:0] cnt;

    // Saturate rather than wrap so a long wait with the timeout disabled
    // can never alias back onto the terminal value.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (count && (cnt != MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && (cnt == LAST);

endmodule

// File: rtl/mem_interface.sv
// mem_interface
// MAR/MDR unit driving an external memory over a req/ack handshake with
// arbitrary wait states and an optional request timeout.
// Ports:
//   clock, clear            clock and asynchronous active-low reset
//   bus_in, MARin, MDRin    internal bus and register load strobes
//   read, write             transaction start (read wins if both)
//   mdr_out, mar_out        register contents
//   mem_req, mem_we         registered request and direction
//   mem_addr, mem_wdata     follow MAR and MDR
//   mem_rdata, mem_ack      memory response
//   busy, done, err         status: in progress, completion pulse, sticky timeout
//   err_clr                 clears err
module mem_interface
    import mem_if_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              read,
    input  logic              write,
    output logic [DATA_W-1:0] mdr_out,
    output logic [ADDR_W-1:0] mar_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              err_clr
);

    state_t            state;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic              timer_start;
    logic              timer_count;
    logic              expired;

    // The timer restarts when a transaction is accepted and advances on
    // every waiting cycle that does not complete.
    assign timer_start = (state == IDLE) && (read || write);
    assign timer_count = (state == ACCESS) && !mem_ack;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock   (clock),
        .clear   (clear),
        .start   (timer_start),
        .count   (timer_count),
        .expired (expired)
    );

    // Single sequential block for the FSM, MAR/MDR and status flags.
    // Register loads and new requests are honoured only in IDLE so the
    // address and data presented to memory stay frozen while it works.
    // err_clr is applied first so a timeout on the same edge overrides it.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state   <= IDLE;
            mar     <= '0;
            mdr     <= '0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (err_clr) begin
                err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (MARin) begin
                        mar <= bus_in[ADDR_W-1:0];
                    end
                    if (MDRin) begin
                        mdr <= bus_in;
                    end
                    if (read || write) begin
                        state   <= ACCESS;
                        mem_req <= 1'b1;
                        mem_we  <= write & ~read;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                        if (!mem_we) begin
                            mdr <= mem_rdata;
                        end
                    end else if (expired) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state == ACCESS);
    assign mar_out   = mar;
    assign mdr_out   = mdr;
    assign mem_addr  = mar;
    assign mem_wdata = mdr;

endmodule

// File: tb/tb_mem_interface.sv
// tb_mem_interface
// Self-checking bench for mem_interface: a transaction-level model tracks
// what every output must be each cycle, directed scenarios pin the model
// with literal values, and a randomized phase exercises the handshake.
// A second instance with the timeout disabled covers long ack delays.
module tb_mem_interface;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int TO = 15;

    logic          clock = 1'b0;
    logic          clear = 1'b0;
    logic [DW-1:0] bus_in = '0;
    logic          MARin = 1'b0;
    logic          MDRin = 1'b0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic          err_clr = 1'b0;

    logic [DW-1:0] mdr_out, mem_wdata, mem_rdata;
    logic [AW-1:0] mar_out, mem_addr;
    logic          mem_req, mem_we, mem_ack, busy, done, err;

    logic [DW-1:0] mdr_out_nt, mem_wdata_nt, mem_rdata_nt;
    logic [AW-1:0] mar_out_nt, mem_addr_nt;
    logic          mem_req_nt, mem_we_nt, mem_ack_nt, busy_nt, done_nt, err_nt;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    mem_interface #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clock(clock), .clear(clear), .bus_in(bus_in), .MARin(MARin), .MDRin(MDRin),
        .read(read), .write(write), .mdr_out(mdr_out), .mar_out(mar_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .done(done), .err(err),
        .err_clr(err_clr)
    );

    mem_interface #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(0)) dut_nt (
        .clock(clock), .clear(clear), .bus_in(bus_in), .MARin(MARin), .MDRin(MDRin),
        .read(read), .write(write), .mdr_out(mdr_out_nt), .mar_out(mar_out_nt),
        .mem_req(mem_req_nt), .mem_we(mem_we_nt), .mem_addr(mem_addr_nt),
        .mem_wdata(mem_wdata_nt), .mem_rdata(mem_rdata_nt), .mem_ack(mem_ack_nt),
        .busy(busy_nt), .done(done_nt), .err(err_nt), .err_clr(err_clr)
    );

    // External memory for the main instance: acks after 'delay' waiting
    // cycles (255 = never), optionally toggles ack randomly while idle.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int  cyc = 0;
    int  delay = 0;
    bit  idle_noise = 1'b0;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = $urandom;
        end
    end

    always @(negedge clock) begin
        if (!clear) begin
            mem_ack = 1'b0;
            cyc     = 0;
        end else if (mem_req) begin
            if (cyc >= delay) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                end else begin
                    mem_rdata = mem[mem_addr];
                end
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
            cyc++;
        end else begin
            cyc       = 0;
            mem_ack   = idle_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = $urandom;
        end
    end

    // Slow memory for the timeout-disabled instance: always 40 wait cycles.
    int cyc_nt = 0;

    initial begin
        mem_ack_nt   = 1'b0;
        mem_rdata_nt = 32'hCAFEF00D;
    end

    always @(negedge clock) begin
        if (!clear) begin
            mem_ack_nt = 1'b0;
            cyc_nt     = 0;
        end else if (mem_req_nt) begin
            mem_ack_nt = (cyc_nt >= 40);
            cyc_nt++;
        end else begin
            mem_ack_nt = 1'b0;
            cyc_nt     = 0;
        end
    end

    // Transaction-level model of the main instance.
    bit            m_busy = 1'b0;
    bit            m_we = 1'b0;
    bit            m_done = 1'b0;
    bit            m_err = 1'b0;
    logic [AW-1:0] m_mar = '0;
    logic [DW-1:0] m_mdr = '0;
    int            m_elapsed = 0;

    task automatic model_step();
        bit timed_out;
        timed_out = 1'b0;
        if (!clear) begin
            m_busy = 0; m_we = 0; m_done = 0; m_err = 0;
            m_mar = '0; m_mdr = '0; m_elapsed = 0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (MARin) m_mar = bus_in[AW-1:0];
                if (MDRin) m_mdr = bus_in;
                if (read || write) begin
                    m_busy    = 1'b1;
                    m_we      = write && !read;
                    m_elapsed = 0;
                end
            end else begin
                m_elapsed++;
                if (mem_ack) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    if (!m_we) m_mdr = mem_rdata;
                end else if (TO != 0 && m_elapsed == TO) begin
                    m_busy    = 1'b0;
                    m_done    = 1'b1;
                    timed_out = 1'b1;
                end
            end
            if (err_clr) m_err = 1'b0;
            if (timed_out) m_err = 1'b1;
        end
    endtask

    task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: model advances on the edge, outputs checked 1 time unit later.
    always @(posedge clock) begin
        model_step();
        #1;
        if (clear) begin
            check_output("mem_req", DW'(mem_req), DW'(m_busy));
            check_output("busy", DW'(busy), DW'(m_busy));
            check_output("done", DW'(done), DW'(m_done));
            check_output("err", DW'(err), DW'(m_err));
            check_output("mar_out", DW'(mar_out), DW'(m_mar));
            check_output("mdr_out", mdr_out, m_mdr);
            check_output("mem_addr", DW'(mem_addr), DW'(m_mar));
            check_output("mem_wdata", mem_wdata, m_mdr);
            if (m_busy) check_output("mem_we", DW'(mem_we), DW'(m_we));
        end
    end

    // Window observer: counts request cycles, rising edges and done pulses,
    // and releases the one-shot stimulus after each observed negedge.
    int w_req, w_we1, w_rise, w_done, w_req_nt, w_we_nt, w_done_nt;
    bit prev_req;

    task automatic watch_reset();
        w_req = 0; w_we1 = 0; w_rise = 0; w_done = 0;
        w_req_nt = 0; w_we_nt = 0; w_done_nt = 0;
        prev_req = mem_req;
    endtask

    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (mem_req) begin
                w_req++;
                if (mem_we) w_we1++;
                if (!prev_req) w_rise++;
            end
            if (done) w_done++;
            prev_req = mem_req;
            if (mem_req_nt) begin
                w_req_nt++;
                if (mem_we_nt) w_we_nt++;
            end
            if (done_nt) w_done_nt++;
            read = 0; write = 0; MARin = 0; MDRin = 0; err_clr = 0;
        end
    endtask

    task automatic apply_stimulus(input int cycles);
        int r;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            bus_in  = $urandom;
            MARin   = ($urandom_range(0, 3) == 0);
            MDRin   = ($urandom_range(0, 3) == 0);
            err_clr = ($urandom_range(0, 7) == 0);
            r       = $urandom_range(0, 5);
            read    = (r == 0) || (r == 2);
            write   = (r == 1) || (r == 2);
            if (!m_busy) begin
                delay = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 4);
            end
        end
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clock);
        check_output("rst_mar", DW'(mar_out), 32'h0);
        check_output("rst_mdr", mdr_out, 32'h0);
        check_output("rst_req", DW'(mem_req), 32'h0);
        check_output("rst_busy", DW'(busy), 32'h0);
        check_output("rst_done", DW'(done), 32'h0);
        check_output("rst_err", DW'(err), 32'h0);
        clear = 1'b1;

        // Zero-wait read
        bus_in = 32'h5; MARin = 1'b1;
        watch(1);
        mem[5] = 32'hDEADBEEF;
        read = 1'b1; delay = 0;
        watch_reset();
        watch(1);
        check_output("zw_req", DW'(mem_req), 32'h1);
        watch(1);
        check_output("zw_data", mdr_out, 32'hDEADBEEF);
        check_output("zw_done", DW'(done), 32'h1);
        check_output("zw_model", m_mdr, 32'hDEADBEEF);
        watch(3);
        check_output("zw_pulses", DW'(w_done), 32'd1);
        check_output("zw_reqlen", DW'(w_req), 32'd1);

        // Write with 3 wait states
        bus_in = 32'h1A0; MARin = 1'b1;
        watch(1);
        bus_in = 32'h12345678; MDRin = 1'b1;
        watch(1);
        write = 1'b1; delay = 3;
        watch_reset();
        watch(10);
        check_output("wr_reqlen", DW'(w_req), 32'd4);
        check_output("wr_we", DW'(w_we1), 32'd4);
        check_output("wr_pulses", DW'(w_done), 32'd1);
        check_output("wr_mem", mem[9'h1A0], 32'h12345678);
        check_output("wr_mdr", mdr_out, 32'h12345678);
        check_output("wr_mar", DW'(mar_out), 32'h1A0);

        // Timeout, then err_clr
        read = 1'b1; delay = 255;
        watch_reset();
        watch(25);
        check_output("to_reqlen", DW'(w_req), 32'd15);
        check_output("to_pulses", DW'(w_done), 32'd1);
        check_output("to_err", DW'(err), 32'h1);
        check_output("to_model_err", DW'(m_err), 32'h1);
        check_output("to_mdr", mdr_out, 32'h12345678);
        err_clr = 1'b1;
        watch(1);
        check_output("to_errclr", DW'(err), 32'h0);

        // Loads and a second read ignored while busy
        delay = 5; read = 1'b1;
        watch_reset();
        watch(1);
        bus_in = 32'h33; MARin = 1'b1;
        watch(1);
        bus_in = 32'hFFFFFFFF; MDRin = 1'b1; read = 1'b1;
        watch(1);
        watch(12);
        check_output("busy_rises", DW'(w_rise), 32'd1);
        check_output("busy_reqlen", DW'(w_req), 32'd6);
        check_output("busy_pulses", DW'(w_done), 32'd1);
        check_output("busy_mar", DW'(mar_out), 32'h1A0);
        check_output("busy_mdr", mdr_out, 32'h12345678);

        // Asynchronous clear in the middle of a transaction
        delay = 255; read = 1'b1;
        watch(3);
        #2 clear = 1'b0;
        #1;
        check_output("arst_req", DW'(mem_req), 32'h0);
        check_output("arst_busy", DW'(busy), 32'h0);
        check_output("arst_done", DW'(done), 32'h0);
        check_output("arst_mar", DW'(mar_out), 32'h0);
        check_output("arst_mdr", mdr_out, 32'h0);
        check_output("arst_req_nt", DW'(mem_req_nt), 32'h0);
        @(negedge clock);
        @(negedge clock);
        clear = 1'b1;

        // Read and write together, timeout disabled, 40 wait cycles
        delay = 2; read = 1'b1; write = 1'b1;
        watch_reset();
        watch(50);
        check_output("nt_reqlen", DW'(w_req_nt), 32'd41);
        check_output("nt_we", DW'(w_we_nt), 32'd0);
        check_output("nt_pulses", DW'(w_done_nt), 32'd1);
        check_output("nt_err", DW'(err_nt), 32'h0);
        check_output("nt_data", mdr_out_nt, 32'hCAFEF00D);
        check_output("rw_we", DW'(w_we1), 32'd0);
        check_output("rw_reqlen", DW'(w_req), 32'd3);

        // Randomized traffic with idle ack noise
        idle_noise = 1'b1;
        apply_stimulus(1500);
        @(negedge clock);
        read = 0; write = 0; MARin = 0; MDRin = 0; err_clr = 0;
        repeat (20) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
